// File: rtl/dispatch_ctrl_pkg.sv
// Shared dispatch-stage types: sequencer states and processor exit status codes.
package sys_defs;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } DISP_STATE;

    typedef enum logic [1:0] {
        EXIT_NONE    = 2'd0,
        EXIT_HALT    = 2'd1,
        EXIT_ILLEGAL = 2'd2
    } EXIT_STATUS;

    // Illegal outranks halt when a slot carries both flags.
    function automatic EXIT_STATUS exit_kind(input logic is_illegal);
        return is_illegal ? EXIT_ILLEGAL : EXIT_HALT;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_fit.sv
// Prefix-sum resource check: fit[i] is set when slots 0..i together fit in every
// free count. Halt/illegal slots only consume a ROB entry.
module dispatch_fit #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 6
) (
    input  logic [WIDTH-1:0] slot_valid,
    input  logic [WIDTH-1:0] slot_halt,
    input  logic [WIDTH-1:0] slot_illegal,
    input  logic [WIDTH-1:0] slot_is_store,
    input  logic [WIDTH-1:0] slot_dest_nz,
    input  logic [CNT_W-1:0] rob_free,
    input  logic [CNT_W-1:0] rs_free,
    input  logic [CNT_W-1:0] fl_free,
    input  logic [CNT_W-1:0] sq_free,
    output logic [WIDTH-1:0] fit
);

    // Wide enough that WIDTH accumulated needs can never wrap.
    localparam int SUM_W = CNT_W + $clog2(WIDTH) + 1;

    logic [WIDTH-1:0][SUM_W-1:0] rob_sum;
    logic [WIDTH-1:0][SUM_W-1:0] rs_sum;
    logic [WIDTH-1:0][SUM_W-1:0] fl_sum;
    logic [WIDTH-1:0][SUM_W-1:0] sq_sum;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
            logic             blocker;
            logic [SUM_W-1:0] rob_need;
            logic [SUM_W-1:0] rs_need;
            logic [SUM_W-1:0] fl_need;
            logic [SUM_W-1:0] sq_need;

            assign blocker  = slot_halt[gi] | slot_illegal[gi];
            assign rob_need = SUM_W'(slot_valid[gi]);
            assign rs_need  = SUM_W'(slot_valid[gi] & ~blocker);
            assign fl_need  = SUM_W'(slot_valid[gi] & ~blocker & slot_dest_nz[gi]);
            assign sq_need  = SUM_W'(slot_valid[gi] & ~blocker & slot_is_store[gi]);

            if (gi == 0) begin : g_first
                assign rob_sum[gi] = rob_need;
                assign rs_sum[gi]  = rs_need;
                assign fl_sum[gi]  = fl_need;
                assign sq_sum[gi]  = sq_need;
            end else begin : g_rest
                assign rob_sum[gi] = rob_sum[gi-1] + rob_need;
                assign rs_sum[gi]  = rs_sum[gi-1]  + rs_need;
                assign fl_sum[gi]  = fl_sum[gi-1]  + fl_need;
                assign sq_sum[gi]  = sq_sum[gi-1]  + sq_need;
            end

            assign fit[gi] = (rob_sum[gi] <= SUM_W'(rob_free)) &&
                             (rs_sum[gi]  <= SUM_W'(rs_free))  &&
                             (fl_sum[gi]  <= SUM_W'(fl_free))  &&
                             (sq_sum[gi]  <= SUM_W'(sq_free));
        end
    endgenerate

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch-stage sequencer: in-order prefix dispatch against backend resources,
// halt/illegal drain handling, exit status and stall-cycle performance counter.
module dispatch_ctrl
    import sys_defs::*;
#(
    parameter int WIDTH  = 2,
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             slot_valid,
    input  logic [WIDTH-1:0]             slot_halt,
    input  logic [WIDTH-1:0]             slot_illegal,
    input  logic [WIDTH-1:0]             slot_is_store,
    input  logic [WIDTH-1:0]             slot_dest_nz,
    input  logic [CNT_W-1:0]             rob_free,
    input  logic [CNT_W-1:0]             rs_free,
    input  logic [CNT_W-1:0]             fl_free,
    input  logic [CNT_W-1:0]             sq_free,
    input  logic                         squash,
    input  logic                         retire_halt,
    output logic [WIDTH-1:0]             dispatch_mask,
    output logic [$clog2(WIDTH+1)-1:0]   dispatch_cnt,
    output logic                         stall,
    output logic [1:0]                   exit_status,
    output logic                         done,
    output logic [PERF_W-1:0]            stall_cycles
);

    localparam int CNT_OUT_W = $clog2(WIDTH + 1);

    DISP_STATE  state_reg;
    EXIT_STATUS pend_kind_reg;

    logic [WIDTH-1:0] fit;
    logic [WIDTH-1:0] blocker;
    logic             dispatch_open;
    logic             hit_blocker;
    logic             hit_illegal;

    dispatch_fit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_fit (
        .slot_valid    (slot_valid),
        .slot_halt     (slot_halt),
        .slot_illegal  (slot_illegal),
        .slot_is_store (slot_is_store),
        .slot_dest_nz  (slot_dest_nz),
        .rob_free      (rob_free),
        .rs_free       (rs_free),
        .fl_free       (fl_free),
        .sq_free       (sq_free),
        .fit           (fit)
    );

    assign blocker       = slot_halt | slot_illegal;
    assign dispatch_open = (state_reg == RUN) && !squash;

    // The prefix closes at the first slot that fails to dispatch or that is itself a blocker.
    always_comb begin
        logic open;
        open          = dispatch_open;
        dispatch_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (open && slot_valid[i] && fit[i]) begin
                dispatch_mask[i] = 1'b1;
            end else begin
                open = 1'b0;
            end
            if (blocker[i]) begin
                open = 1'b0;
            end
        end
    end

    always_comb begin
        dispatch_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dispatch_cnt = dispatch_cnt + CNT_OUT_W'(dispatch_mask[i]);
        end
    end

    assign hit_blocker = |(dispatch_mask & blocker);
    assign hit_illegal = |(dispatch_mask & slot_illegal);
    assign stall       = dispatch_open && slot_valid[0] && !dispatch_mask[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= RUN;
            pend_kind_reg <= EXIT_NONE;
            exit_status   <= EXIT_NONE;
            done          <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (hit_blocker) begin
                        state_reg     <= DRAIN;
                        pend_kind_reg <= exit_kind(hit_illegal);
                    end
                end
                DRAIN: begin
                    // A retiring halt is architecturally committed, so it beats a same-cycle squash.
                    if (retire_halt) begin
                        state_reg   <= DONE;
                        exit_status <= pend_kind_reg;
                        done        <= 1'b1;
                    end else if (squash) begin
                        state_reg     <= RUN;
                        pend_kind_reg <= EXIT_NONE;
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural dispatch/exit model.
module tb_dispatch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  slot_valid, slot_halt, slot_illegal, slot_is_store, slot_dest_nz;
    logic [5:0]  rob_free, rs_free, fl_free, sq_free;
    logic        squash, retire_halt;
    logic [1:0]  dispatch_mask;
    logic [1:0]  dispatch_cnt;
    logic        stall;
    logic [1:0]  exit_status;
    logic        done;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0=running, 1=waiting for halt retire, 2=finished.
    int         m_state, m_pend, m_exit;
    bit         m_done;
    longint     m_stalls;
    logic [1:0] e_mask;
    int         e_cnt;
    bit         e_stall;

    dispatch_ctrl #(.WIDTH(2), .CNT_W(6), .PERF_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .slot_valid    (slot_valid),
        .slot_halt     (slot_halt),
        .slot_illegal  (slot_illegal),
        .slot_is_store (slot_is_store),
        .slot_dest_nz  (slot_dest_nz),
        .rob_free      (rob_free),
        .rs_free       (rs_free),
        .fl_free       (fl_free),
        .sq_free       (sq_free),
        .squash        (squash),
        .retire_halt   (retire_halt),
        .dispatch_mask (dispatch_mask),
        .dispatch_cnt  (dispatch_cnt),
        .stall         (stall),
        .exit_status   (exit_status),
        .done          (done),
        .stall_cycles  (stall_cycles)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        m_state  = 0;
        m_pend   = 0;
        m_exit   = 0;
        m_done   = 0;
        m_stalls = 0;
    endfunction

    function automatic void model_comb();
        int rob_u, rs_u, fl_u, sq_u;
        bit b;
        rob_u = 0; rs_u = 0; fl_u = 0; sq_u = 0;
        e_mask = 2'b00;
        if (m_state == 0 && !squash) begin
            for (int i = 0; i < 2; i++) begin
                b = slot_halt[i] || slot_illegal[i];
                if (!slot_valid[i]) break;
                rob_u += 1;
                if (!b) rs_u += 1;
                if (!b && slot_dest_nz[i]) fl_u += 1;
                if (!b && slot_is_store[i]) sq_u += 1;
                if (rob_u > int'(rob_free) || rs_u > int'(rs_free) ||
                    fl_u > int'(fl_free) || sq_u > int'(sq_free)) break;
                e_mask[i] = 1'b1;
                if (b) break;
            end
        end
        e_cnt   = $countones(e_mask);
        e_stall = (m_state == 0) && !squash && slot_valid[0] && !e_mask[0];
    endfunction

    function automatic void model_seq();
        if (m_state == 0) begin
            if ((e_mask & (slot_halt | slot_illegal)) != 2'b00) begin
                m_state = 1;
                m_pend  = ((e_mask & slot_illegal) != 2'b00) ? 2 : 1;
            end
        end else if (m_state == 1) begin
            if (retire_halt) begin
                m_state = 2;
                m_exit  = m_pend;
                m_done  = 1;
            end else if (squash) begin
                m_state = 0;
                m_pend  = 0;
            end
        end
        if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    endfunction

    task automatic drive(input logic [1:0] v, h, il, st, dn,
                         input int rob, rs, fl, sq, input logic sqs, ret);
        @(negedge clock);
        slot_valid = v; slot_halt = h; slot_illegal = il;
        slot_is_store = st; slot_dest_nz = dn;
        rob_free = 6'(rob); rs_free = 6'(rs); fl_free = 6'(fl); sq_free = 6'(sq);
        squash = sqs; retire_halt = ret;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clock);
        model_seq();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        slot_valid = 2'b00; squash = 1'b0; retire_halt = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        slot_valid = 2'b00; slot_halt = 2'b00; slot_illegal = 2'b00;
        slot_is_store = 2'b00; slot_dest_nz = 2'b00;
        rob_free = 6'd0; rs_free = 6'd0; fl_free = 6'd0; sq_free = 6'd0;
        squash = 1'b0; retire_halt = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (exit_status !== 2'd0) begin n_bad++; $display("FAIL reset_exit: got %0d want 0", exit_status); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stalls: got %0d want 0", stall_cycles); end
        n_cmp++; if (dispatch_mask !== 2'b00) begin n_bad++; $display("FAIL reset_mask: got %b want 00", dispatch_mask); end
        @(negedge clock);
        reset = 1'b0;
        $display("reset: exit=%0d done=%b stalls=%0d", exit_status, done, stall_cycles);
    endtask

    task automatic test_rob_stall();
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0, 8, 8, 8, 1'b0, 1'b0);
            n_cmp++; if (dispatch_mask !== 2'b00) begin n_bad++; $display("FAIL rob_stall_mask: got %b want 00", dispatch_mask); end
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rob_stall_flag: got %b want 1", stall); end
            tick();
            $display("rob_stall cycle %0d: mask=%b stall=%b stalls=%0d", k, dispatch_mask, stall, stall_cycles);
        end
        n_cmp++; if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL rob_stall_count: got %0d want 5", stall_cycles); end
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall: got %b want 0", stall); end
        tick();
        n_cmp++; if (stall_cycles !== 32'd5) begin n_bad++; $display("FAIL idle_count: got %0d want 5", stall_cycles); end
    endtask

    task automatic test_full_dispatch();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b11) begin n_bad++; $display("FAIL full_mask: got %b want 11", dispatch_mask); end
        n_cmp++; if (dispatch_cnt !== 2'd2) begin n_bad++; $display("FAIL full_cnt: got %0d want 2", dispatch_cnt); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL full_stall: got %b want 0", stall); end
        $display("full: mask=%b cnt=%0d stall=%b", dispatch_mask, dispatch_cnt, stall);
        tick();
        drive(2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 8, 8, 8, 1, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b01) begin n_bad++; $display("FAIL sq_limit_mask: got %b want 01", dispatch_mask); end
        n_cmp++; if (dispatch_cnt !== 2'd1) begin n_bad++; $display("FAIL sq_limit_cnt: got %0d want 1", dispatch_cnt); end
        $display("sq_limit: mask=%b cnt=%0d", dispatch_mask, dispatch_cnt);
        tick();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b1, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b00) begin n_bad++; $display("FAIL squash_run_mask: got %b want 00", dispatch_mask); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL squash_run_stall: got %b want 0", stall); end
        $display("squash_run: mask=%b stall=%b", dispatch_mask, stall);
        tick();
    endtask

    task automatic test_fl_limit();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 1, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b01) begin n_bad++; $display("FAIL fl1_mask: got %b want 01", dispatch_mask); end
        $display("fl_free=1: mask=%b", dispatch_mask);
        tick();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 8, 8, 0, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b01) begin n_bad++; $display("FAIL fl0_mask: got %b want 01", dispatch_mask); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl0_stall: got %b want 0", stall); end
        $display("fl_free=0: mask=%b stall=%b", dispatch_mask, stall);
        tick();
    endtask

    task automatic test_halt();
        drive(2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 8, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b01) begin n_bad++; $display("FAIL halt_mask: got %b want 01", dispatch_mask); end
        tick();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b00) begin n_bad++; $display("FAIL drain_mask: got %b want 00", dispatch_mask); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL drain_stall: got %b want 0", stall); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL drain_done: got %b want 0", done); end
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b0, 1'b1);
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL halt_done: got %b want 1", done); end
        n_cmp++; if (exit_status !== 2'd1) begin n_bad++; $display("FAIL halt_exit: got %0d want 1", exit_status); end
        $display("halt retired: done=%b exit=%0d", done, exit_status);
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b1, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b00) begin n_bad++; $display("FAIL done_mask: got %b want 00", dispatch_mask); end
        tick();
        n_cmp++; if (done !== 1'b1 || exit_status !== 2'd1) begin n_bad++; $display("FAIL done_hold: got done=%b exit=%0d want done=1 exit=1", done, exit_status); end
        do_reset();
    endtask

    task automatic test_illegal_squash();
        drive(2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 8, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b11) begin n_bad++; $display("FAIL ill1_mask: got %b want 11", dispatch_mask); end
        tick();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b1, 1'b0);
        tick();
        n_cmp++; if (exit_status !== 2'd0 || done !== 1'b0) begin n_bad++; $display("FAIL squash_drain: got exit=%0d done=%b want exit=0 done=0", exit_status, done); end
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b11) begin n_bad++; $display("FAIL resume_mask: got %b want 11", dispatch_mask); end
        $display("squashed illegal: mask=%b exit=%0d", dispatch_mask, exit_status);
        tick();
        drive(2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 8, 8, 8, 8, 1'b0, 1'b0);
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8, 8, 8, 8, 1'b1, 1'b1);
        tick();
        n_cmp++; if (done !== 1'b1 || exit_status !== 2'd2) begin n_bad++; $display("FAIL ill_retire: got done=%b exit=%0d want done=1 exit=2", done, exit_status); end
        $display("illegal retired with squash: done=%b exit=%0d", done, exit_status);
        do_reset();
        drive(2'b11, 2'b01, 2'b01, 2'b00, 2'b11, 8, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b01) begin n_bad++; $display("FAIL both_mask: got %b want 01", dispatch_mask); end
        tick();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8, 8, 8, 8, 1'b0, 1'b1);
        tick();
        n_cmp++; if (exit_status !== 2'd2) begin n_bad++; $display("FAIL both_exit: got %0d want 2", exit_status); end
        $display("halt+illegal slot: exit=%0d", exit_status);
        do_reset();
    endtask

    task automatic test_async_reset();
        drive(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 8, 8, 8, 1'b0, 1'b0);
        tick();
        n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL pre_reset_stalls: got %0d want 1", stall_cycles); end
        drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 8, 8, 8, 8, 1'b0, 1'b0);
        tick();
        drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8, 8, 8, 8, 1'b0, 1'b0);
        n_cmp++; if (dispatch_mask !== 2'b00) begin n_bad++; $display("FAIL pre_reset_drain: got %b want 00", dispatch_mask); end
        reset = 1'b1;
        #1;
        n_cmp++; if (dispatch_mask !== 2'b11) begin n_bad++; $display("FAIL async_mask: got %b want 11", dispatch_mask); end
        n_cmp++; if (done !== 1'b0 || stall_cycles !== 32'd0) begin n_bad++; $display("FAIL async_state: got done=%b stalls=%0d want done=0 stalls=0", done, stall_cycles); end
        $display("async reset mid-drain: mask=%b done=%b stalls=%0d", dispatch_mask, done, stall_cycles);
        reset = 1'b0;
        model_reset();
        model_comb();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] v, h, il, st, dn;
        int fr[4];
        for (int n = 0; n < 400; n++) begin
            v  = 2'($urandom_range(0, 3));
            h  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            il = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            st = 2'($urandom_range(0, 3)) & ~(h | il);
            dn = 2'($urandom_range(0, 3));
            for (int r = 0; r < 4; r++) fr[r] = ($urandom_range(0, 3) == 0) ? 63 : $urandom_range(0, 3);
            drive(v, h, il, st, dn, fr[0], fr[1], fr[2], fr[3],
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
            n_cmp++; if (dispatch_mask !== e_mask) begin n_bad++; $display("FAIL rnd_mask[%0d]: got %b want %b", n, dispatch_mask, e_mask); end
            n_cmp++; if (dispatch_cnt !== 2'(e_cnt)) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, dispatch_cnt, e_cnt); end
            n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, e_stall); end
            tick();
            n_cmp++; if (exit_status !== 2'(m_exit) || done !== m_done) begin n_bad++; $display("FAIL rnd_exit[%0d]: got exit=%0d done=%b want exit=%0d done=%b", n, exit_status, done, m_exit, m_done); end
            n_cmp++; if (stall_cycles !== 32'(m_stalls)) begin n_bad++; $display("FAIL rnd_stalls[%0d]: got %0d want %0d", n, stall_cycles, m_stalls); end
            $display("rnd %0d: v=%b h=%b il=%b mask=%b stall=%b exit=%0d done=%b", n, v, h, il, dispatch_mask, stall, exit_status, done);
            if (m_done && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_rob_stall();
        test_full_dispatch();
        test_fl_limit();
        test_halt();
        test_illegal_squash();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
